// File: rtl/imul_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier controller: one shifted partial-product
// row is added into a double-width accumulator per clock.
//
// state | meaning
// IDLE  | waiting for iStart; no operation in flight
// RUN   | adding row k of the partial-product array, k = 0..NB-1
// DONE  | oResult just updated, oDone pulses; a new start may be accepted here
module imul_seq_ctrl #(
  parameter int NB = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [NB-1:0]   iA,
  input  logic [NB-1:0]   iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [2*NB-1:0] oResult
);

  localparam int KW = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [NB-1:0]   r_a;
  logic [NB-1:0]   r_b;
  logic [2*NB-1:0] r_acc;
  logic [KW-1:0]   r_k;
  logic [2*NB-1:0] r_result;
  logic            r_busy;
  logic            r_done;

  logic [2*NB-1:0] w_row;
  logic [2*NB-1:0] w_acc_next;
  logic            w_last;

  // Multiplier bit k gates the multiplicand; the row lands at weight 2^k.
  assign w_row      = r_b[r_k[KW-2:0]] ? ({{NB{1'b0}}, r_a} << r_k) : '0;
  assign w_acc_next = r_acc + w_row;
  assign w_last     = (r_k == KW'(NB - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (iStart) begin
            r_a   <= iA;
            r_b   <= iB;
            r_acc <= '0;
            r_k   <= '0;
            if (iA == '0 || iB == '0) begin
              r_state  <= DONE;
              r_result <= '0;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          if (w_last) begin
            r_result <= w_acc_next;
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule

// File: tb/tb_imul_seq_ctrl.sv
// Directed and randomized checks of imul_seq_ctrl against plain A*B arithmetic
// and the stated start-to-done latencies.
module tb_imul_seq_ctrl;

  localparam int NB = 16;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            iStart = 1'b0;
  logic [NB-1:0]   iA = '0;
  logic [NB-1:0]   iB = '0;
  logic            oBusy;
  logic            oDone;
  logic [2*NB-1:0] oResult;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int starts = 0;
  bit mon_en = 1'b0;
  logic [2*NB-1:0] last_result = '0;

  imul_seq_ctrl #(.NB(NB)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result must only move on a done pulse; busy and done are exclusive.
  always @(negedge Clock) begin
    if (oDone) done_cnt++;
    if (mon_en) begin
      check("busy_done_excl", {63'd0, oBusy & oDone}, 64'd0);
      if (oDone) last_result = oResult;
      else check("result_stable", {32'd0, oResult}, {32'd0, last_result});
    end
  end

  // Present operands at a negedge so the next posedge accepts them.
  task automatic start_now(input logic [NB-1:0] a, input logic [NB-1:0] b);
    iStart = 1'b1; iA = a; iB = b;
    @(negedge Clock);
    iStart = 1'b0;
    starts++;
  endtask

  // Called in the cycle after acceptance; returns cycles from acceptance to done.
  task automatic wait_done(output int cyc, output int busy);
    cyc = 1; busy = 0;
    while (!oDone && cyc < 100) begin
      if (oBusy) busy++;
      @(negedge Clock);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b);
    int cyc, busy;
    logic [2*NB-1:0] exp;
    exp = 32'(a) * 32'(b);
    start_now(a, b);
    wait_done(cyc, busy);
    check({tag, "_result"}, {32'd0, oResult}, {32'd0, exp});
    check({tag, "_latency"}, 64'(cyc), (a == 0 || b == 0) ? 64'd1 : 64'd17);
    check({tag, "_busy_cycles"}, 64'(busy), (a == 0 || b == 0) ? 64'd0 : 64'd16);
  endtask

  initial begin
    int cyc, busy, d0;
    logic [NB-1:0] ra, rb;

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("reset_busy", {63'd0, oBusy}, 64'd0);
    check("reset_done", {63'd0, oDone}, 64'd0);
    check("reset_result", {32'd0, oResult}, 64'd0);
    mon_en = 1'b1;
    @(negedge Clock);

    run_op("a3_b5", 16'd3, 16'd5);
    @(negedge Clock);
    run_op("ffff_sq", 16'hFFFF, 16'hFFFF);
    run_op("zero_a", 16'h0000, 16'h1234);
    run_op("zero_b", 16'h1234, 16'h0000);
    @(negedge Clock);

    // Start requests during RUN must be ignored.
    start_now(16'd7, 16'd9);
    repeat (3) @(negedge Clock);
    iStart = 1'b1; iA = 16'hAAAA; iB = 16'hAAAA;
    repeat (3) @(negedge Clock);
    iStart = 1'b0;
    cyc = 0;
    while (!oDone && cyc < 100) begin @(negedge Clock); cyc++; end
    check("run_ignore_result", {32'd0, oResult}, 64'd63);
    // Back-to-back start in the DONE cycle.
    run_op("b2b", 16'h8000, 16'd2);
    check("b2b_value", {32'd0, oResult}, 64'h0001_0000);
    @(negedge Clock);

    // Reset in the 8th RUN cycle aborts without a done pulse.
    start_now(16'd100, 16'd200);
    starts--;
    repeat (7) @(negedge Clock);
    mon_en = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", {63'd0, oBusy}, 64'd0);
    check("abort_done", {63'd0, oDone}, 64'd0);
    check("abort_result", {32'd0, oResult}, 64'd0);
    last_result = '0;
    mon_en = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge Clock);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_op("after_abort", 16'd100, 16'd200);
    check("after_abort_value", {32'd0, oResult}, 64'h0000_4E20);

    for (int i = 0; i < 200; i++) begin
      ra = NB'($urandom);
      rb = NB'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      run_op("rand", ra, rb);
    end

    repeat (3) @(negedge Clock);
    check("done_count", 64'(done_cnt), 64'(starts));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
